seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes eight hex digits onto one shared set of active-low cathodes.
// A 3-bit digit index goes to an external 3-to-8 anode decoder. Display data is
// double-buffered and becomes active only at the 7->0 wrap of the scan. Because
// of this, a frame never mixes old and new data.
//
// Ports
//   clk               system clock
//   reset_n           synchronous reset, active-low
//   value[31:0]       display data, nibble i belongs to digit i
//   dp_in[7:0]        decimal-point request per digit, active-high
//   digit_en[7:0]     per-digit enable, 0 blanks the digit
//   blank_lead_zeros  suppress leading zero digits (digit 0 always shown)
//   load              strobe: capture value/dp_in into the pending buffer
//   load_ack          one-cycle pulse when pending data becomes active
//   digit_sel[2:0]    current digit index for the anode decoder
//   segments[6:0]     {g,f,e,d,c,b,a}, active-low
//   dp                decimal point, active-low
//   frame_start       one-cycle pulse on the first cycle with digit_sel = 0

module seg7_scan_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] value,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   input  logic        blank_lead_zeros,
   input  logic        load,
   output logic        load_ack,
   output logic [2:0]  digit_sel,
   output logic [6:0]  segments,
   output logic        dp,
   output logic        frame_start
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [31:0]   active_val, pending_val;
   logic [7:0]    active_dp, pending_dp;
   logic          pending_valid;

   logic          tick, wrap;
   logic [2:0]    sel_nxt;
   logic [31:0]   act_val_nxt, pend_val_nxt, upper;
   logic [7:0]    act_dp_nxt, pend_dp_nxt;
   logic          pv_nxt, ack_nxt, blank;
   logic [3:0]    nib;
   logic [6:0]    seg_code;

   assign tick    = (prescaler == PRE_MAX);
   assign wrap    = tick && (digit_sel == 3'd7);
   assign sel_nxt = digit_sel + 3'd1;

   // Buffer update. A load that lands on the wrap tick goes straight to
   // active, so the ack is not held back by a whole frame.
   always_comb begin
      act_val_nxt  = active_val;
      act_dp_nxt   = active_dp;
      pend_val_nxt = pending_val;
      pend_dp_nxt  = pending_dp;
      pv_nxt       = pending_valid;
      ack_nxt      = 1'b0;
      if (wrap) begin
         if (load) begin
            act_val_nxt = value;
            act_dp_nxt  = dp_in;
            pv_nxt      = 1'b0;
            ack_nxt     = 1'b1;
         end else if (pending_valid) begin
            act_val_nxt = pending_val;
            act_dp_nxt  = pending_dp;
            pv_nxt      = 1'b0;
            ack_nxt     = 1'b1;
         end
      end else if (load) begin
         pend_val_nxt = value;
         pend_dp_nxt  = dp_in;
         pv_nxt       = 1'b1;
      end
   end

   // Segment source for the slot about to start. The source is the post-commit
   // data, so digit 0 shows the new value on the frame where it commits.
   // upper holds nibbles 7..sel. When it is zero, every digit from sel up is a
   // leading zero.
   always_comb begin
      upper = act_val_nxt >> {sel_nxt, 2'b00};
      nib   = upper[3:0];
      blank = ~digit_en[sel_nxt] |
              (blank_lead_zeros && (sel_nxt != 3'd0) && (upper == 32'd0));
      case (nib)
         4'h0:    seg_code = 7'b1000000;
         4'h1:    seg_code = 7'b1111001;
         4'h2:    seg_code = 7'b0100100;
         4'h3:    seg_code = 7'b0110000;
         4'h4:    seg_code = 7'b0011001;
         4'h5:    seg_code = 7'b0010010;
         4'h6:    seg_code = 7'b0000010;
         4'h7:    seg_code = 7'b1111000;
         4'h8:    seg_code = 7'b0000000;
         4'h9:    seg_code = 7'b0010000;
         4'hA:    seg_code = 7'b0001000;
         4'hB:    seg_code = 7'b0000011;
         4'hC:    seg_code = 7'b1000110;
         4'hD:    seg_code = 7'b0100001;
         4'hE:    seg_code = 7'b0000110;
         default: seg_code = 7'b0001110;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prescaler     <= '0;
         digit_sel     <= 3'd0;
         active_val    <= 32'd0;
         active_dp     <= 8'd0;
         pending_val   <= 32'd0;
         pending_dp    <= 8'd0;
         pending_valid <= 1'b0;
         segments      <= 7'h7F;
         dp            <= 1'b1;
         load_ack      <= 1'b0;
         frame_start   <= 1'b0;
      end else begin
         prescaler     <= tick ? '0 : prescaler + PW'(1);
         active_val    <= act_val_nxt;
         active_dp     <= act_dp_nxt;
         pending_val   <= pend_val_nxt;
         pending_dp    <= pend_dp_nxt;
         pending_valid <= pv_nxt;
         load_ack      <= ack_nxt;
         frame_start   <= wrap;
         if (tick) begin
            digit_sel <= sel_nxt;
            segments  <= blank ? 7'h7F : seg_code;
            dp        <= blank ? 1'b1 : ~act_dp_nxt[sel_nxt];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV = 4. The reference
// model works from elapsed cycles since reset: slot = n / 4, digit = slot % 8,
// and a frame wraps every 32 cycles. Expected outputs are queued per clock
// and checked by an independent monitor on the falling edge.

module tb_seg7_scan_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] value = 32'd0;
   logic [7:0]  dp_in = 8'd0;
   logic [7:0]  digit_en = 8'hFF;
   logic        blank_lead_zeros = 1'b0;
   logic        load = 1'b0;
   logic        load_ack;
   logic [2:0]  digit_sel;
   logic [6:0]  segments;
   logic        dp;
   logic        frame_start;

   seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .blank_lead_zeros(blank_lead_zeros), .load(load),
      .load_ack(load_ack), .digit_sel(digit_sel), .segments(segments),
      .dp(dp), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ds;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic       ack;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   acks_expected = 0;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // model state
   int          m_n = 0;
   logic [31:0] m_act = 0, m_pend = 0;
   logic [7:0]  m_adp = 0, m_pdp = 0;
   logic        m_pv = 0, m_ack = 0;
   logic [6:0]  m_seg = 7'h7F;
   logic        m_dp = 1'b1;

   task automatic step();
      int d;
      logic bl;
      logic [31:0] up;
      exp_t e;
      @(posedge clk);
      if (!reset_n) begin
         m_n = 0; m_act = 0; m_adp = 0; m_pend = 0; m_pdp = 0; m_pv = 0;
         m_seg = 7'h7F; m_dp = 1'b1; m_ack = 1'b0;
      end else begin
         m_n++;
         m_ack = 1'b0;
         if (m_n % FRAME == 0) begin
            if (load) begin
               m_act = value; m_adp = dp_in; m_pv = 0; m_ack = 1'b1;
            end else if (m_pv) begin
               m_act = m_pend; m_adp = m_pdp; m_pv = 0; m_ack = 1'b1;
            end
         end else if (load) begin
            m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
         end
         if (m_n % DIV == 0) begin
            d  = (m_n / DIV) % 8;
            up = m_act >> (4 * d);
            bl = !digit_en[d] || (blank_lead_zeros && d != 0 && up == 0);
            m_seg = bl ? 7'h7F : hex_tab[up[3:0]];
            m_dp  = bl ? 1'b1 : !m_adp[d];
         end
      end
      if (m_ack) acks_expected++;
      e.ds  = 3'((m_n / DIV) % 8);
      e.seg = m_seg;
      e.dp  = m_dp;
      e.fs  = (m_n > 0) && (m_n % FRAME == 0);
      e.ack = m_ack;
      q.push_back(e);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] d);
      value = v; dp_in = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (digit_sel !== e.ds) begin
               fails++;
               $display("FAIL digit_sel t=%0t got %0d want %0d", $time, digit_sel, e.ds);
            end
            tests++;
            if (segments !== e.seg) begin
               fails++;
               $display("FAIL segments t=%0t sel=%0d got %b want %b", $time, digit_sel, segments, e.seg);
            end
            tests++;
            if (dp !== e.dp) begin
               fails++;
               $display("FAIL dp t=%0t sel=%0d got %b want %b", $time, digit_sel, dp, e.dp);
            end
            tests++;
            if (frame_start !== e.fs) begin
               fails++;
               $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, e.fs);
            end
            tests++;
            if (load_ack !== e.ack) begin
               fails++;
               $display("FAIL load_ack t=%0t got %b want %b", $time, load_ack, e.ack);
            end
         end
      end
   end

   initial begin
      int acks_before;
      logic [31:0] rv;
      // reset and free-run
      reset_n = 1'b0;
      run(2);
      reset_n = 1'b1;
      run(40);

      // mid-frame load, visible only after wrap
      while (m_n % FRAME != 12) step();
      do_load(32'h0123_89AF, 8'h00);
      run(2 * FRAME);

      // leading-zero blanking
      blank_lead_zeros = 1'b1;
      do_load(32'h0000_0040, 8'h00);
      run(2 * FRAME);
      do_load(32'h0000_0000, 8'h00);
      run(2 * FRAME);
      blank_lead_zeros = 1'b0;

      // two loads in one frame produce one ack
      while (m_n % FRAME != 3) step();
      acks_before = acks_expected;
      do_load(32'h1111_1111, 8'h00);
      run(5);
      do_load(32'h2222_2222, 8'h00);
      run(2 * FRAME);
      tests++;
      if (acks_expected - acks_before != 1) begin
         fails++;
         $display("FAIL double_load_acks got %0d want 1", acks_expected - acks_before);
      end

      // load exactly on the commit tick (bypass)
      while ((m_n + 1) % FRAME != 0) step();
      do_load(32'hFEDC_BA98, 8'hA5);
      run(2 * FRAME);

      // randomized traffic
      for (int i = 0; i < 1200; i++) begin
         if (i % 64 == 0) begin
            digit_en = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            blank_lead_zeros = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 15) == 0) begin
            rv = $urandom;
            rv = rv >> $urandom_range(0, 31);
            do_load(rv, 8'($urandom));
         end else begin
            value = $urandom;
            dp_in = 8'($urandom);
            step();
         end
      end

      // digit 0 only with dp, then reset mid-frame with data pending
      digit_en = 8'hFE;
      blank_lead_zeros = 1'b0;
      digit_en = 8'h01;
      do_load(32'h0000_0007, 8'h01);
      run(2 * FRAME);
      while (m_n % FRAME != 14) step();
      do_load(32'h0000_0003, 8'h01);
      run(3);
      reset_n = 1'b0;
      run(2);
      reset_n = 1'b1;
      digit_en = 8'hFF;
      run(2 * FRAME + 5);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got %0d left want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
